bip_control_unit: RTL

Instruction sequencer and decoder of the BIP core. It sits directly upstream of the program counter. It fetches the instruction that program memory returns for the current PC, decodes it, and drives the datapath strobes. It also drives the PC write strobe and the next PC value (WrPC / address_bus). It runs from a start pulse until it executes HLT, and counts clock cycles for the host.

---
 rtl/bip_control_unit_if.sv | 30 +++
 rtl/bip_control_unit.sv | 74 +++++++
 2 files changed

// File: rtl/bip_control_unit_if.sv
// bip_control_unit_if: host/program-memory/datapath bus of the BIP control unit.
interface bip_control_unit_if #(
  parameter int AB  = 11,
  parameter int OPW = 5,
  parameter int CW  = 16
);
  logic              start;
  logic [OPW+AB-1:0] instr;
  logic [AB-1:0]     pc_addr;
  logic [AB-1:0]     next_addr;
  logic              WrPC;
  logic [AB-1:0]     operand;
  logic [1:0]        SelA;
  logic              SelB;
  logic              Op;
  logic              WrACC;
  logic              WrRAM;
  logic              RdRAM;
  logic              busy;
  logic              halted;
  logic [CW-1:0]     cycle_count;
  modport master (
    input  start, instr, pc_addr,
    output next_addr, WrPC, operand, SelA, SelB, Op, WrACC, WrRAM, RdRAM, busy, halted, cycle_count
  );
  modport slave (
    output start, instr, pc_addr,
    input  next_addr, WrPC, operand, SelA, SelB, Op, WrACC, WrRAM, RdRAM, busy, halted, cycle_count
  );
endinterface

// File: rtl/bip_control_unit.sv
// bip_control_unit: two-cycle fetch/execute sequencer and decoder of the BIP core.
module bip_control_unit #(
  parameter int AB  = 11,
  parameter int OPW = 5,
  parameter int CW  = 16
) (
  input logic clk,
  input logic rst_n,
  bip_control_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t            state;
  logic [OPW+AB-1:0] ir;
  logic [OPW-1:0]    op_in, ir_op;
  logic              alu;
  assign op_in = bus.instr[OPW+AB-1:AB];
  assign ir_op = ir[OPW+AB-1:AB];
  assign alu   = (op_in >> 2) == OPW'(1);
  assign bus.next_addr = bus.pc_addr + AB'(1);
  // Strobes are loaded from the decoded instruction at the edge entering EXEC,
  // so instr never reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ir              <= '0;
      bus.cycle_count <= '0;
      bus.operand     <= '0;
      bus.WrPC        <= 1'b0;
      bus.WrACC       <= 1'b0;
      bus.WrRAM       <= 1'b0;
      bus.RdRAM       <= 1'b0;
      bus.SelA        <= 2'b00;
      bus.SelB        <= 1'b0;
      bus.Op          <= 1'b0;
      bus.busy        <= 1'b0;
      bus.halted      <= 1'b0;
    end else begin
      if ((state == FETCH || state == EXEC) && bus.cycle_count != '1)
        bus.cycle_count <= bus.cycle_count + CW'(1);
      case (state)
        IDLE: if (bus.start) begin
          state    <= FETCH;
          bus.busy <= 1'b1;
        end
        FETCH: begin
          state       <= EXEC;
          ir          <= bus.instr;
          bus.operand <= bus.instr[AB-1:0];
          bus.WrPC    <= op_in != '0;
          bus.WrRAM   <= op_in == OPW'(1);
          bus.RdRAM   <= op_in == OPW'(2) || op_in == OPW'(4) || op_in == OPW'(6);
          bus.WrACC   <= op_in == OPW'(2) || op_in == OPW'(3) || alu;
          bus.SelA    <= op_in == OPW'(3) ? 2'b01 : alu ? 2'b10 : 2'b00;
          bus.SelB    <= op_in == OPW'(5) || op_in == OPW'(7);
          bus.Op      <= op_in == OPW'(6) || op_in == OPW'(7);
        end
        EXEC: begin
          state       <= ir_op == '0 ? HALT : FETCH;
          bus.busy    <= ir_op != '0;
          bus.halted  <= ir_op == '0;
          bus.operand <= '0;
          bus.WrPC    <= 1'b0;
          bus.WrACC   <= 1'b0;
          bus.WrRAM   <= 1'b0;
          bus.RdRAM   <= 1'b0;
          bus.SelA    <= 2'b00;
          bus.SelB    <= 1'b0;
          bus.Op      <= 1'b0;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule
